prime_gen: RTL and testbench

Sequential prime-number generator: after a start pulse it enumerates every prime p with 2 ≤ p ≤ 2^WIDTH−1 in ascending order and presents each on a valid/ready output stream. It is the producing counterpart of the team's combinational prime checker. Its stream can drive a checker directly, and every emitted value must be judged prime. Primality is decided internally by trial division using repeated subtraction; the block contains no hardware divider or multiplier-based modulo.

---
 rtl/prime_gen.sv | 201 ++++++++++++++++++++
 tb/tb_prime_gen.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_gen.sv
`default_nettype none
// ============================================================================
// Module      : prime_gen
// Description : Sequential prime enumerator. After a start pulse it walks
//               every candidate 2 .. 2^WIDTH-1 in ascending order, decides
//               primality by trial division using repeated subtraction, and
//               presents each prime on a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module prime_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] prime,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_TEST = 3'd2,
        S_SUB  = 3'd3,
        S_EMIT = 3'd4,
        S_NEXT = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam logic [WIDTH-1:0]   C_CAND_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   C_ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0]   C_TWO      = WIDTH'(2);
    localparam logic [2*WIDTH-1:0] C_FOUR     = (2*WIDTH)'(4);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_cand;     // candidate under test
    logic [WIDTH-1:0]   r_d;        // current trial divisor
    logic [2*WIDTH-1:0] r_dsq;      // r_d squared, tracked incrementally
    logic [WIDTH-1:0]   r_rem;      // running remainder of r_cand / r_d
    logic [WIDTH-1:0]   r_prime;    // value presented on the stream
    logic [WIDTH-1:0]   r_count;    // handshakes since the last start

    logic [2*WIDTH-1:0] w_cand_ext;
    logic [2*WIDTH-1:0] w_dsq_inc;
    logic               w_rem_ge_d;
    logic               w_rem_zero;
    logic               w_root_passed;
    logic               w_cand_small;
    logic               w_cand_last;

    // (d+1)^2 = d^2 + 2d + 1, so the square is kept without a multiplier;
    // {r_d, 1'b1} is exactly 2d+1 and the sum is held at double width.
    assign w_cand_ext    = {{WIDTH{1'b0}}, r_cand};
    assign w_dsq_inc     = r_dsq + {{(WIDTH-1){1'b0}}, r_d, 1'b1};
    assign w_rem_ge_d    = (r_rem >= r_d);
    assign w_rem_zero    = (r_rem == '0);
    assign w_root_passed = (w_dsq_inc > w_cand_ext);
    assign w_cand_small  = (C_FOUR > w_cand_ext);
    assign w_cand_last   = (r_cand == C_CAND_MAX);

    // State register; reset drops any in-flight prime immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and output decode from the registered state.
    always_comb begin
        w_state_nxt = r_state;
        valid       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        prime       = r_prime;
        count       = r_count;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_INIT;
                end
            end
            S_INIT: begin
                busy        = 1'b1;
                w_state_nxt = S_TEST;
            end
            S_TEST: begin
                busy = 1'b1;
                // 2 and 3 have no divisor d with d*d <= cand.
                if (w_cand_small) begin
                    w_state_nxt = S_EMIT;
                end else begin
                    w_state_nxt = S_SUB;
                end
            end
            S_SUB: begin
                busy = 1'b1;
                if (!w_rem_ge_d) begin
                    if (w_rem_zero) begin
                        w_state_nxt = S_NEXT;
                    end else if (w_root_passed) begin
                        w_state_nxt = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                busy  = 1'b1;
                valid = 1'b1;
                if (ready) begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                busy = 1'b1;
                if (w_cand_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_TEST;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_state_nxt = S_INIT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Candidate / divisor / remainder datapath, stream value and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cand  <= '0;
            r_d     <= '0;
            r_dsq   <= '0;
            r_rem   <= '0;
            r_prime <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // Clear on the accepting edge so count reads 0 as soon
                    // as busy rises.
                    if (start) begin
                        r_count <= '0;
                    end
                end
                S_INIT: begin
                    r_cand  <= C_TWO;
                    r_count <= '0;
                end
                S_TEST: begin
                    r_d   <= C_TWO;
                    r_dsq <= C_FOUR;
                    r_rem <= r_cand;
                    if (w_cand_small) begin
                        r_prime <= r_cand;
                    end
                end
                S_SUB: begin
                    if (w_rem_ge_d) begin
                        r_rem <= r_rem - r_d;
                    end else if (!w_rem_zero) begin
                        // Divisor does not divide: advance to the next one.
                        r_d   <= r_d + C_ONE;
                        r_dsq <= w_dsq_inc;
                        r_rem <= r_cand;
                        if (w_root_passed) begin
                            r_prime <= r_cand;
                        end
                    end
                end
                S_EMIT: begin
                    if (ready) begin
                        r_count <= r_count + C_ONE;
                    end
                end
                S_NEXT: begin
                    // Terminal check precedes the increment so cand never wraps.
                    if (!w_cand_last) begin
                        r_cand <= r_cand + C_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prime_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_prime_gen
// Description : Scoreboard bench for prime_gen. Four instances run in
//               parallel: WIDTH=3, WIDTH=4, WIDTH=8 with random ready, and
//               WIDTH=8 exercising a mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prime_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    logic rst_v   [4];
    logic start_v [4];
    logic ready_v [4];
    logic valid_v [4];
    logic busy_v  [4];
    logic done_v  [4];
    int   prime_v [4];
    int   count_v [4];

    logic [2:0] p3, c3;
    logic [3:0] p4, c4;
    logic [7:0] p8a, c8a, p8b, c8b;

    assign prime_v[0] = int'(p3);
    assign count_v[0] = int'(c3);
    assign prime_v[1] = int'(p4);
    assign count_v[1] = int'(c4);
    assign prime_v[2] = int'(p8a);
    assign count_v[2] = int'(c8a);
    assign prime_v[3] = int'(p8b);
    assign count_v[3] = int'(c8b);

    prime_gen #(.WIDTH(3)) u_w3 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .ready(ready_v[0]),
        .valid(valid_v[0]), .prime(p3), .busy(busy_v[0]), .done(done_v[0]), .count(c3));
    prime_gen #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .ready(ready_v[1]),
        .valid(valid_v[1]), .prime(p4), .busy(busy_v[1]), .done(done_v[1]), .count(c4));
    prime_gen #(.WIDTH(8)) u_w8a (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .ready(ready_v[2]),
        .valid(valid_v[2]), .prime(p8a), .busy(busy_v[2]), .done(done_v[2]), .count(c8a));
    prime_gen #(.WIDTH(8)) u_w8b (
        .clk(clk), .rst(rst_v[3]), .start(start_v[3]), .ready(ready_v[3]),
        .valid(valid_v[3]), .prime(p8b), .busy(busy_v[3]), .done(done_v[3]), .count(c8b));

    // Hand-listed primes below 256.
    int P8 [54] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53,
                    59, 61, 67, 71, 73, 79, 83, 89, 97, 101, 103, 107, 109, 113,
                    127, 131, 137, 139, 149, 151, 157, 163, 167, 173, 179, 181,
                    191, 193, 197, 199, 211, 223, 227, 229, 233, 239, 241, 251};

    int q0[$], q1[$], q2[$], q3[$];
    int acc  [4];
    int last [4];
    logic pv [4];
    logic pr [4];
    int   pp [4];

    function automatic void push_exp(int k, int v);
        case (k)
            0: q0.push_back(v);
            1: q1.push_back(v);
            2: q2.push_back(v);
            default: q3.push_back(v);
        endcase
    endfunction

    function automatic void push_list(int k, int n);
        for (int i = 0; i < n; i++) push_exp(k, P8[i]);
    endfunction

    function automatic int qsize(int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic int pop_exp(int k);
        case (k)
            0: return q0.pop_front();
            1: return q1.pop_front();
            2: return q2.pop_front();
            default: return q3.pop_front();
        endcase
    endfunction

    // Stand-in for the combinational checker tap.
    function automatic int is_prime(int v);
        if (v < 2) return 0;
        for (int d = 2; d * d <= v; d++) begin
            if (v % d == 0) return 0;
        end
        return 1;
    endfunction

    function automatic void chk(int k, string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL dut%0d %s: got %0d, expected %0d at %0t", k, name, act, exp, $time);
        end
    endfunction

    // Monitor: pops the scoreboard on every handshake and checks stream rules.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst_v[k]) begin
                pv[k] = 1'b0;
                pr[k] = 1'b0;
            end else begin
                if (pv[k] && !pr[k]) begin
                    chk(k, "hold_valid", int'(valid_v[k]), 1);
                    chk(k, "hold_prime", prime_v[k], pp[k]);
                end
                if (pv[k] && pr[k]) begin
                    chk(k, "gap_after_handshake", int'(valid_v[k]), 0);
                end
                if (valid_v[k] && ready_v[k]) begin
                    if (qsize(k) == 0) begin
                        chk(k, "unexpected_prime", prime_v[k], -1);
                    end else begin
                        chk(k, "prime", prime_v[k], pop_exp(k));
                    end
                    chk(k, "count_at_handshake", count_v[k], acc[k]);
                    if (k == 0) chk(k, "checker_tap", is_prime(prime_v[k]), 1);
                    acc[k]++;
                    last[k] = prime_v[k];
                end
                pv[k] = valid_v[k];
                pr[k] = ready_v[k];
                pp[k] = prime_v[k];
            end
        end
    end

    task automatic pulse_start(int k);
        @(posedge clk);
        #1 start_v[k] = 1'b1;
        @(posedge clk);
        #1 start_v[k] = 1'b0;
    endtask

    task automatic wait_done(int k, int bound);
        int n = 0;
        while (!done_v[k] && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(k, "done_within_bound", int'(done_v[k]), 1);
    endtask

    task automatic check_started(int k);
        @(posedge clk);
        @(negedge clk);
        chk(k, "busy_after_start", int'(busy_v[k]), 1);
        chk(k, "done_after_start", int'(done_v[k]), 0);
        chk(k, "count_after_start", count_v[k], 0);
    endtask

    task automatic test_w3();
        ready_v[0] = 1'b1;
        push_list(0, 4);
        pulse_start(0);
        check_started(0);
        wait_done(0, 256);
        chk(0, "final_count", count_v[0], 4);
        chk(0, "final_busy", int'(busy_v[0]), 0);
        chk(0, "queue_drained", qsize(0), 0);
        chk(0, "last_prime", last[0], 7);
    endtask

    task automatic test_w4();
        int n;
        ready_v[1] = 1'b0;
        push_list(1, 6);
        pulse_start(1);
        check_started(1);
        n = 0;
        while (!valid_v[1] && n < 1024) begin
            @(negedge clk);
            n++;
        end
        chk(1, "first_valid_within_bound", int'(valid_v[1]), 1);
        repeat (10) begin
            @(negedge clk);
            chk(1, "stall_valid", int'(valid_v[1]), 1);
            chk(1, "stall_prime", prime_v[1], 2);
            chk(1, "stall_count", count_v[1], 0);
        end
        @(posedge clk);
        #1 ready_v[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk(1, "count_after_release", count_v[1], 1);
        n = 0;
        while (count_v[1] < 3 && n < 1024) begin
            @(negedge clk);
            n++;
        end
        chk(1, "count3_within_bound", count_v[1], 3);
        pulse_start(1);
        @(negedge clk);
        chk(1, "busy_after_ignored_start", int'(busy_v[1]), 1);
        wait_done(1, 1024);
        chk(1, "final_count", count_v[1], 6);
        chk(1, "final_busy", int'(busy_v[1]), 0);
        chk(1, "queue_drained", qsize(1), 0);
        chk(1, "last_prime", last[1], 13);
        // Restart from DONE.
        push_list(1, 6);
        acc[1] = 0;
        pulse_start(1);
        check_started(1);
        wait_done(1, 1024);
        chk(1, "restart_count", count_v[1], 6);
        chk(1, "restart_queue_drained", qsize(1), 0);
    endtask

    task automatic test_w8_random();
        int n;
        ready_v[2] = 1'b1;
        push_list(2, 54);
        pulse_start(2);
        n = 0;
        while (!done_v[2] && n < 262144) begin
            @(posedge clk);
            #1 ready_v[2] = ($urandom_range(0, 1) == 1);
            n++;
        end
        @(negedge clk);
        chk(2, "done_within_bound", int'(done_v[2]), 1);
        chk(2, "final_count", count_v[2], 54);
        chk(2, "queue_drained", qsize(2), 0);
        chk(2, "last_prime", last[2], 251);
    endtask

    task automatic test_w8_reset();
        int n;
        ready_v[3] = 1'b1;
        push_list(3, 25);
        pulse_start(3);
        n = 0;
        while (!(valid_v[3] && prime_v[3] == 97) && n < 262144) begin
            @(negedge clk);
            n++;
        end
        chk(3, "reached_97", prime_v[3], 97);
        #1 rst_v[3] = 1'b1;
        #1;
        chk(3, "rst_valid", int'(valid_v[3]), 0);
        chk(3, "rst_busy", int'(busy_v[3]), 0);
        chk(3, "rst_done", int'(done_v[3]), 0);
        chk(3, "rst_count", count_v[3], 0);
        chk(3, "rst_prime", prime_v[3], 0);
        chk(3, "queue_drained_at_rst", qsize(3), 0);
        acc[3] = 0;
        repeat (2) @(posedge clk);
        #1 rst_v[3] = 1'b0;
        push_list(3, 54);
        pulse_start(3);
        check_started(3);
        wait_done(3, 262144);
        chk(3, "rerun_count", count_v[3], 54);
        chk(3, "rerun_queue_drained", qsize(3), 0);
        chk(3, "rerun_last_prime", last[3], 251);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            rst_v[k]   = 1'b1;
            start_v[k] = 1'b0;
            ready_v[k] = 1'b0;
            acc[k]     = 0;
            last[k]    = -1;
            pv[k]      = 1'b0;
            pr[k]      = 1'b0;
            pp[k]      = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk(k, "reset_valid", int'(valid_v[k]), 0);
            chk(k, "reset_prime", prime_v[k], 0);
            chk(k, "reset_busy", int'(busy_v[k]), 0);
            chk(k, "reset_done", int'(done_v[k]), 0);
            chk(k, "reset_count", count_v[k], 0);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) rst_v[k] = 1'b0;
        fork
            test_w3();
            test_w4();
            test_w8_random();
            test_w8_reset();
        join
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
